// File: rtl/parrot_anim_ctrl_pkg.sv
`default_nettype none
// ------------------------------------------------------------------
// parrot_pkg : mode encoding and default sizing for the sequencer
// rev 1.0
// ------------------------------------------------------------------
package parrot_pkg;

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        PARTY  = 2'd1,
        PAUSED = 2'd2
    } anim_mode_t;

    localparam int NUM_FRAMES_DEF  = 10;
    localparam int FRAME_WORDS_DEF = 16384;
    localparam int NORMAL_DIV_DEF  = 4;
    localparam int PARTY_DIV_DEF   = 1;
    localparam int HUE_W           = 3;

endpackage
`default_nettype wire

// File: rtl/parrot_anim_ctrl_btn_debounce.sv
`default_nettype none
// ------------------------------------------------------------------
// btn_debounce : 2-FF synchronizer, debounce counter, level + press pulse
// rev 1.0
// ------------------------------------------------------------------
module btn_debounce #(
    parameter int DEBOUNCE_CYC = 360000
) (
    input  logic clk,
    input  logic res_n,
    input  logic btn_n,
    output logic pressed,
    output logic press
);
    localparam int CNT_W = (DEBOUNCE_CYC > 1) ? $clog2(DEBOUNCE_CYC) : 1;

    logic             sync1;
    logic             sync2;
    logic             raw_pressed;
    logic [CNT_W-1:0] cnt;

    assign raw_pressed = ~sync2;

    always_ff @(posedge clk) begin
        if (!res_n) begin
            sync1   <= 1'b1;
            sync2   <= 1'b1;
            cnt     <= '0;
            pressed <= 1'b0;
            press   <= 1'b0;
        end else begin
            sync1 <= btn_n;
            sync2 <= sync1;
            press <= 1'b0;
            // The accepting cycle is the DEBOUNCE_CYC-th consecutive mismatch
            if (raw_pressed != pressed) begin
                if (cnt == CNT_W'(DEBOUNCE_CYC - 1)) begin
                    cnt     <= '0;
                    pressed <= raw_pressed;
                    press   <= raw_pressed;
                end else begin
                    cnt <= cnt + CNT_W'(1);
                end
            end else begin
                cnt <= '0;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/parrot_anim_ctrl.sv
`default_nettype none
// ------------------------------------------------------------------
// parrot_anim_ctrl : button-driven mode FSM, vsync divider, frame/hue counters
// rev 1.0
// ------------------------------------------------------------------
module parrot_anim_ctrl
    import parrot_pkg::*;
#(
    parameter int NUM_FRAMES   = NUM_FRAMES_DEF,
    parameter int FRAME_W      = 4,
    parameter int FRAME_WORDS  = FRAME_WORDS_DEF,
    parameter int ADDR_W       = 20,
    parameter int NORMAL_DIV   = NORMAL_DIV_DEF,
    parameter int PARTY_DIV    = PARTY_DIV_DEF,
    parameter int DEBOUNCE_CYC = 360000
) (
    input  logic               clk36m,
    input  logic               i_res_n,
    input  logic               btn_a,
    input  logic               btn_b,
    input  logic               lcd_vsync,
    output logic [FRAME_W-1:0] frame_idx,
    output logic [ADDR_W-1:0]  frame_base,
    output logic               frame_stb,
    output logic [HUE_W-1:0]   hue_shift,
    output logic [1:0]         mode
);
    localparam int DIV_MAX = (NORMAL_DIV > PARTY_DIV) ? NORMAL_DIV : PARTY_DIV;
    localparam int VS_W    = (DIV_MAX > 1) ? $clog2(DIV_MAX) : 1;

    anim_mode_t      state;
    anim_mode_t      state_nxt;
    logic            a_lvl;
    logic            b_press;
    logic            unused_a_press;
    logic            unused_b_lvl;
    logic            vs_q;
    logic            tick;
    logic            div_hit;
    logic [VS_W-1:0] vs_cnt;

    btn_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_deb_a (
        .clk     (clk36m),
        .res_n   (i_res_n),
        .btn_n   (btn_a),
        .pressed (a_lvl),
        .press   (unused_a_press)
    );

    btn_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_deb_b (
        .clk     (clk36m),
        .res_n   (i_res_n),
        .btn_n   (btn_b),
        .pressed (unused_b_lvl),
        .press   (b_press)
    );

    assign tick    = vs_q & ~lcd_vsync;
    assign div_hit = (state == PARTY) ? (vs_cnt == VS_W'(PARTY_DIV - 1))
                                      : (vs_cnt == VS_W'(NORMAL_DIV - 1));
    assign mode    = state;

    // A B press takes priority over any A level change in the same cycle
    always_comb begin
        state_nxt = state;
        case (state)
            RUN:     if (b_press) state_nxt = PAUSED;
                     else if (a_lvl) state_nxt = PARTY;
            PARTY:   if (b_press) state_nxt = PAUSED;
                     else if (!a_lvl) state_nxt = RUN;
            PAUSED:  if (b_press) state_nxt = a_lvl ? PARTY : RUN;
            default: state_nxt = RUN;
        endcase
    end

    always_ff @(posedge clk36m) begin
        if (!i_res_n) begin
            state      <= RUN;
            vs_q       <= 1'b1;
            vs_cnt     <= '0;
            frame_idx  <= '0;
            frame_base <= '0;
            frame_stb  <= 1'b0;
            hue_shift  <= '0;
        end else begin
            vs_q      <= lcd_vsync;
            frame_stb <= 1'b0;
            state     <= state_nxt;
            // A mode change swallows any coincident tick
            if (state_nxt != state) begin
                vs_cnt <= '0;
                if (state_nxt == RUN)
                    hue_shift <= '0;
            end else if (tick && state != PAUSED) begin
                if (div_hit) begin
                    vs_cnt    <= '0;
                    frame_stb <= 1'b1;
                    if (frame_idx == FRAME_W'(NUM_FRAMES - 1)) begin
                        frame_idx  <= '0;
                        frame_base <= '0;
                    end else begin
                        frame_idx  <= frame_idx + FRAME_W'(1);
                        frame_base <= frame_base + ADDR_W'(FRAME_WORDS);
                    end
                    if (state == PARTY)
                        hue_shift <= hue_shift + HUE_W'(1);
                end else begin
                    vs_cnt <= vs_cnt + VS_W'(1);
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_parrot_anim_ctrl.sv
`default_nettype none
// ------------------------------------------------------------------
// tb_parrot_anim_ctrl : scoreboard bench for the parrot animation sequencer
// rev 1.0
// ------------------------------------------------------------------
module tb_parrot_anim_ctrl;

    logic        clk36m;
    logic        i_res_n;
    logic        btn_a;
    logic        btn_b;
    logic        lcd_vsync;
    logic [3:0]  frame_idx;
    logic [19:0] frame_base;
    logic        frame_stb;
    logic [2:0]  hue_shift;
    logic [1:0]  mode;

    parrot_anim_ctrl #(
        .NUM_FRAMES   (3),
        .FRAME_W      (4),
        .FRAME_WORDS  (100),
        .ADDR_W       (20),
        .NORMAL_DIV   (4),
        .PARTY_DIV    (1),
        .DEBOUNCE_CYC (4)
    ) dut (
        .clk36m     (clk36m),
        .i_res_n    (i_res_n),
        .btn_a      (btn_a),
        .btn_b      (btn_b),
        .lcd_vsync  (lcd_vsync),
        .frame_idx  (frame_idx),
        .frame_base (frame_base),
        .frame_stb  (frame_stb),
        .hue_shift  (hue_shift),
        .mode       (mode)
    );

    typedef struct {
        int idx;
        int base;
        int hue;
        int md;
    } stb_exp_t;

    stb_exp_t stb_q[$];
    int       mode_q[$];
    int       checks = 0;
    int       errs   = 0;
    logic     mon_on = 1'b0;

    initial clk36m = 1'b0;
    always #5 clk36m = ~clk36m;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errs++;
            $display("FAIL %s: actual %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic push_stb(input int idx, input int base, input int hue, input int md);
        stb_exp_t e;
        e.idx = idx; e.base = base; e.hue = hue; e.md = md;
        stb_q.push_back(e);
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge clk36m);
    endtask

    task automatic vs_tick();
        @(negedge clk36m);
        lcd_vsync = 1'b0;
        @(negedge clk36m);
        lcd_vsync = 1'b1;
        wait_cyc(2);
    endtask

    task automatic press_b();
        @(negedge clk36m);
        btn_b = 1'b0;
        wait_cyc(10);
        btn_b = 1'b1;
        wait_cyc(10);
    endtask

    task automatic check_drained(input string name);
        chk({name, "_stb_pending"}, stb_q.size(), 0);
        chk({name, "_mode_pending"}, mode_q.size(), 0);
    endtask

    // Monitor: every strobe and every mode change must match the next queued entry
    initial begin
        int       prev_mode;
        stb_exp_t e;
        wait (mon_on);
        prev_mode = int'(mode);
        forever begin
            @(negedge clk36m);
            if (frame_stb) begin
                if (stb_q.size() == 0) begin
                    checks++;
                    errs++;
                    $display("FAIL unexpected_stb: actual frame_idx %0d, expected no strobe", frame_idx);
                end else begin
                    e = stb_q.pop_front();
                    chk("stb_frame_idx", int'(frame_idx), e.idx);
                    chk("stb_frame_base", int'(frame_base), e.base);
                    chk("stb_hue_shift", int'(hue_shift), e.hue);
                    chk("stb_mode", int'(mode), e.md);
                end
            end
            if (int'(mode) != prev_mode) begin
                if (mode_q.size() == 0) begin
                    checks++;
                    errs++;
                    $display("FAIL unexpected_mode_change: actual %0d, expected %0d", mode, prev_mode);
                end else begin
                    chk("mode_change", int'(mode), mode_q.pop_front());
                end
            end
            prev_mode = int'(mode);
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: actual timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        i_res_n   = 1'b0;
        btn_a     = 1'b1;
        btn_b     = 1'b1;
        lcd_vsync = 1'b1;
        wait_cyc(3);
        chk("rst_mode", int'(mode), 0);
        chk("rst_frame_idx", int'(frame_idx), 0);
        chk("rst_frame_base", int'(frame_base), 0);
        chk("rst_frame_stb", int'(frame_stb), 0);
        chk("rst_hue_shift", int'(hue_shift), 0);
        mon_on = 1'b1;
        @(negedge clk36m);
        i_res_n = 1'b1;
        wait_cyc(2);

        // RUN: one advance per four ticks
        push_stb(1, 100, 0, 0);
        push_stb(2, 200, 0, 0);
        push_stb(0, 0, 0, 0);
        repeat (12) vs_tick();
        check_drained("run");

        // PARTY: advance every tick, hue rotates
        mode_q.push_back(1);
        btn_a = 1'b0;
        wait_cyc(10);
        push_stb(1, 100, 1, 1);
        push_stb(2, 200, 2, 1);
        push_stb(0, 0, 3, 1);
        push_stb(1, 100, 4, 1);
        push_stb(2, 200, 5, 1);
        repeat (5) vs_tick();
        mode_q.push_back(0);
        btn_a = 1'b1;
        wait_cyc(10);
        chk("party_exit_hue", int'(hue_shift), 0);
        check_drained("party");

        // Pause with vs_cnt = 2, ticks ignored, resume restarts divider
        repeat (2) vs_tick();
        mode_q.push_back(2);
        press_b();
        chk("pause_mode", int'(mode), 2);
        repeat (8) vs_tick();
        chk("pause_hold_idx", int'(frame_idx), 2);
        mode_q.push_back(0);
        press_b();
        repeat (3) vs_tick();
        chk("resume_hold_idx", int'(frame_idx), 2);
        push_stb(0, 0, 0, 0);
        vs_tick();
        check_drained("pause");

        // Glitch rejection then a single accepted press
        @(negedge clk36m);
        btn_b = 1'b0;
        wait_cyc(3);
        btn_b = 1'b1;
        wait_cyc(12);
        chk("glitch_mode", int'(mode), 0);
        mode_q.push_back(2);
        btn_b = 1'b0;
        wait_cyc(6);
        btn_b = 1'b1;
        wait_cyc(15);
        chk("long_pulse_mode", int'(mode), 2);
        check_drained("glitch");

        // PAUSED ignores A level; B press with A held goes to PARTY
        btn_a = 1'b0;
        wait_cyc(10);
        chk("paused_ignores_a", int'(mode), 2);
        mode_q.push_back(1);
        press_b();
        chk("unpause_to_party", int'(mode), 1);

        // B press event and vsync tick land on the same edge
        mode_q.push_back(2);
        @(negedge clk36m);
        btn_b = 1'b0;
        wait_cyc(6);
        lcd_vsync = 1'b0;
        @(negedge clk36m);
        lcd_vsync = 1'b1;
        wait_cyc(10);
        btn_b = 1'b1;
        wait_cyc(10);
        chk("simul_frame_idx", int'(frame_idx), 0);
        chk("simul_mode", int'(mode), 2);
        check_drained("simul");

        // Back to PARTY, 14 advances reach frame 2 / hue 6
        mode_q.push_back(1);
        press_b();
        for (int k = 1; k <= 14; k++)
            push_stb(k % 3, (k % 3) * 100, k % 8, 1);
        repeat (14) vs_tick();
        chk("pre_reset_idx", int'(frame_idx), 2);
        chk("pre_reset_hue", int'(hue_shift), 6);
        check_drained("party14");

        // Reset mid-operation
        mode_q.push_back(0);
        @(negedge clk36m);
        i_res_n = 1'b0;
        @(negedge clk36m);
        chk("mid_rst_mode", int'(mode), 0);
        chk("mid_rst_frame_idx", int'(frame_idx), 0);
        chk("mid_rst_frame_base", int'(frame_base), 0);
        chk("mid_rst_frame_stb", int'(frame_stb), 0);
        chk("mid_rst_hue_shift", int'(hue_shift), 0);
        i_res_n = 1'b1;
        mode_q.push_back(1);
        wait_cyc(10);
        chk("post_rst_party", int'(mode), 1);
        mode_q.push_back(0);
        btn_a = 1'b1;
        wait_cyc(10);
        check_drained("final");

        $display("End of test - %0d assertions evaluated, %0d failures", checks, errs);
        $finish;
    end

endmodule
`default_nettype wire
